id_ex_stage: RTL

- ID/EX pipeline stage directly downstream of the main control decoder in the pipelined MIPS core.
- Registers the decoder's control bundle together with operands, immediate, PC and register specifiers for the EX stage.
- Resolves the write-destination register.
- Detects load-use hazards, inserts bubbles and stalls upstream; honours branch/jump flush from EX and memory-side hold.

---
 rtl/id_ex_stage.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// +--------------------------------------------------------------------------+
// | id_ex_stage : ID/EX pipeline register with load-use stall and bubbling   |
// | Optional HAZARD_CNT_EN: saturating load-use bubble counter on bubble_cnt |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module id_ex_stage #(
  parameter int DW       = 32,
  parameter int RW       = 5,
  parameter int LINK_REG = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_B,
  input  logic          id_J,
  input  logic          id_RegDst,
  input  logic          id_RegWr,
  input  logic          id_MenWr,
  input  logic          id_MentoReg,
  input  logic          id_ALUSrc,
  input  logic          id_Extop,
  input  logic          id_r,
  input  logic [4:0]    id_ALUop,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          ex_flush,
  input  logic          mem_hold,
  output logic          ex_valid,
  output logic          ex_B,
  output logic          ex_J,
  output logic          ex_RegWr,
  output logic          ex_MenWr,
  output logic          ex_MentoReg,
  output logic          ex_ALUSrc,
  output logic          ex_Extop,
  output logic          ex_r,
  output logic [4:0]    ex_ALUop,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_dst,
  output logic          stall_up,
  output logic [15:0]   bubble_cnt
);

  localparam logic [4:0]    C_ALUOP_NOP = 5'b11111;
  localparam logic [RW-1:0] C_LINK      = RW'(LINK_REG);

  logic          valid_q, valid_d;
  logic          b_q, b_d, j_q, j_d, regwr_q, regwr_d, menwr_q, menwr_d;
  logic          mentoreg_q, mentoreg_d, alusrc_q, alusrc_d;
  logic          extop_q, extop_d, r_q, r_d;
  logic [4:0]    aluop_q, aluop_d;
  logic [DW-1:0] pc_q, pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, dst_q, dst_d;

  logic          rt_used;
  logic          load_use;
  logic          lu_bubble;
  logic [RW-1:0] dst_res;

  always_comb begin
    if (id_J && id_RegWr)  dst_res = C_LINK;
    else if (id_RegDst)    dst_res = id_rd;
    else                   dst_res = id_rt;

    rt_used  = !id_ALUSrc || id_MenWr || id_B;
    load_use = valid_q && mentoreg_q && (dst_q != '0) && id_valid &&
               ((dst_q == id_rs) || (rt_used && (dst_q == id_rt)));
  end

  always_comb begin
    valid_d    = valid_q;
    b_d        = b_q;
    j_d        = j_q;
    regwr_d    = regwr_q;
    menwr_d    = menwr_q;
    mentoreg_d = mentoreg_q;
    alusrc_d   = alusrc_q;
    extop_d    = extop_q;
    r_d        = r_q;
    aluop_d    = aluop_q;
    pc_d       = pc_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    dst_d      = dst_q;
    stall_up   = 1'b0;
    lu_bubble  = 1'b0;

    if (mem_hold) begin
      stall_up = 1'b1;
    end else if (ex_flush || load_use) begin
      // Bubble: datapath registers simply keep their old contents
      stall_up   = !ex_flush;
      lu_bubble  = !ex_flush;
      valid_d    = 1'b0;
      b_d        = 1'b0;
      j_d        = 1'b0;
      regwr_d    = 1'b0;
      menwr_d    = 1'b0;
      mentoreg_d = 1'b0;
      aluop_d    = C_ALUOP_NOP;
    end else begin
      valid_d    = id_valid;
      b_d        = id_valid && id_B;
      j_d        = id_valid && id_J;
      regwr_d    = id_valid && id_RegWr;
      menwr_d    = id_valid && id_MenWr;
      mentoreg_d = id_valid && id_MentoReg;
      alusrc_d   = id_ALUSrc;
      extop_d    = id_Extop;
      r_d        = id_r;
      aluop_d    = id_ALUop;
      pc_d       = id_pc;
      rs_data_d  = id_rs_data;
      rt_data_d  = id_rt_data;
      imm_d      = id_imm;
      rs_d       = id_rs;
      rt_d       = id_rt;
      dst_d      = dst_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      b_q        <= 1'b0;
      j_q        <= 1'b0;
      regwr_q    <= 1'b0;
      menwr_q    <= 1'b0;
      mentoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      extop_q    <= 1'b0;
      r_q        <= 1'b0;
      aluop_q    <= C_ALUOP_NOP;
      pc_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dst_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      b_q        <= b_d;
      j_q        <= j_d;
      regwr_q    <= regwr_d;
      menwr_q    <= menwr_d;
      mentoreg_q <= mentoreg_d;
      alusrc_q   <= alusrc_d;
      extop_q    <= extop_d;
      r_q        <= r_d;
      aluop_q    <= aluop_d;
      pc_q       <= pc_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dst_q      <= dst_d;
    end
  end

`ifdef HAZARD_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (lu_bubble && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'h0000;
    else        cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;
`else
  logic unused_lu_bubble;
  assign unused_lu_bubble = lu_bubble;
  assign bubble_cnt       = 16'h0000;
`endif

  assign ex_valid    = valid_q;
  assign ex_B        = b_q;
  assign ex_J        = j_q;
  assign ex_RegWr    = regwr_q;
  assign ex_MenWr    = menwr_q;
  assign ex_MentoReg = mentoreg_q;
  assign ex_ALUSrc   = alusrc_q;
  assign ex_Extop    = extop_q;
  assign ex_r        = r_q;
  assign ex_ALUop    = aluop_q;
  assign ex_pc       = pc_q;
  assign ex_rs_data  = rs_data_q;
  assign ex_rt_data  = rt_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_dst      = dst_q;

endmodule

`default_nettype wire
